can_message_fifo: RTL and testbench

//  - Parametrised multi-entry receive buffer between the CAN frame decoder and the message validator/host side.
//  - Holds up to DEPTH frames (identifier, DLC, data, frame type) in arrival order.
//  - Consumer drains frames over a show-ahead valid/ready interface.
//  - Reports fill level, full/empty/almost-full and a saturating overflow count.

---
 rtl/can_message_fifo_pkg.sv | 33 +++
 rtl/can_message_fifo_if.sv | 49 ++++
 rtl/can_message_fifo_ptr_ctrl.sv | 108 ++++++++++
 rtl/can_message_fifo.sv | 88 ++++++++
 tb/tb_can_message_fifo.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/can_message_fifo_pkg.sv
// Shared CAN message types for the receive FIFO: frame record, frame type
// constants and the DLC-to-byte-count decode.
package can_msg_pkg;

    localparam int unsigned CAN_ID_MAX_W   = 29;
    localparam int unsigned CAN_DATA_MAX_W = 64;
    localparam int unsigned CAN_MAX_BYTES  = 8;

    typedef enum logic {
        CAN_FRAME_DATA   = 1'b0,
        CAN_FRAME_REMOTE = 1'b1
    } can_frame_e;

    // Fields sized for the widest build; narrower builds keep the low bits.
    typedef struct packed {
        logic [CAN_ID_MAX_W-1:0]   identifier;
        logic [3:0]                dlc;
        logic [CAN_DATA_MAX_W-1:0] data;
        can_frame_e                frame_type;
    } can_msg_t;

    // Remote frames carry no payload; DLC codes above 8 still mean 8 bytes.
    function automatic logic [3:0] dlc_to_bytes(input logic [3:0] dlc, input can_frame_e ft);
        if (ft == CAN_FRAME_REMOTE) begin
            return 4'd0;
        end
        if (dlc > 4'(CAN_MAX_BYTES)) begin
            return 4'(CAN_MAX_BYTES);
        end
        return dlc;
    endfunction

endpackage

// File: rtl/can_message_fifo_if.sv
// Decoder-side write bus, consumer-side show-ahead read bus and FIFO status
// for can_message_fifo. master = decoder/consumer, slave = the FIFO.
interface can_message_fifo_if #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ID_WIDTH   = 11,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned OVF_CNT_W  = 8
);
    localparam int unsigned FILL_W = $clog2(DEPTH) + 1;

    logic                  rx_message_valid;
    logic [ID_WIDTH-1:0]   received_identifier;
    logic [3:0]            received_dlc;
    logic [DATA_WIDTH-1:0] received_data;
    logic                  received_frame_type;

    logic                  out_valid;
    logic                  out_ready;
    logic [ID_WIDTH-1:0]   out_identifier;
    logic [3:0]            out_dlc;
    logic [3:0]            out_byte_count;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_frame_type;

    logic                  new_message_available;
    logic [FILL_W-1:0]     fill_level;
    logic                  buffer_full;
    logic                  buffer_empty;
    logic                  almost_full;
    logic                  overflow_pulse;
    logic [OVF_CNT_W-1:0]  overflow_count;

    modport master (
        output rx_message_valid, received_identifier, received_dlc, received_data,
               received_frame_type, out_ready,
        input  out_valid, out_identifier, out_dlc, out_byte_count, out_data, out_frame_type,
               new_message_available, fill_level, buffer_full, buffer_empty, almost_full,
               overflow_pulse, overflow_count
    );

    modport slave (
        input  rx_message_valid, received_identifier, received_dlc, received_data,
               received_frame_type, out_ready,
        output out_valid, out_identifier, out_dlc, out_byte_count, out_data, out_frame_type,
               new_message_available, fill_level, buffer_full, buffer_empty, almost_full,
               overflow_pulse, overflow_count
    );

endinterface

// File: rtl/can_message_fifo_ptr_ctrl.sv
// Pointer/occupancy control for can_message_fifo: read/write pointers, fill
// level, full/empty/almost-full, overflow detection and saturating count.
// Optional CAN_MSG_FIFO_OVERWRITE_EN: a push into a full FIFO with no pop
// replaces the oldest entry instead of being dropped.
module can_fifo_ptr_ctrl #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned AFULL_LEVEL = DEPTH - 1,
    parameter int unsigned OVF_CNT_W   = 8,
    localparam int unsigned PTR_W      = $clog2(DEPTH),
    localparam int unsigned FILL_W     = PTR_W + 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 push_i,
    input  logic                 pop_req_i,
    output logic                 wr_en_o,
    output logic [PTR_W-1:0]     wr_ptr_o,
    output logic [PTR_W-1:0]     rd_ptr_o,
    output logic [FILL_W-1:0]    fill_level_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 almost_full_o,
    output logic                 new_msg_o,
    output logic                 ovf_pulse_o,
    output logic [OVF_CNT_W-1:0] ovf_count_o
);

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]    count_q, count_d;
    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic                 new_msg_q, new_msg_d;
    logic                 ovf_pulse_q, ovf_pulse_d;

    logic full, empty, pop, ovf, wr_en, rd_adv;

    assign full  = (count_q == FILL_W'(DEPTH));
    assign empty = (count_q == '0);

    // Next-state for pointers, occupancy and overflow bookkeeping.
    always_comb begin
        pop    = !empty && pop_req_i;
        ovf    = push_i && full && !pop;
`ifdef CAN_MSG_FIFO_OVERWRITE_EN
        // On overflow the slot at wr_ptr is the oldest entry (pointers are
        // equal when full), so writing it and advancing rd_ptr drops the oldest.
        wr_en  = push_i;
        rd_adv = pop || ovf;
`else
        wr_en  = push_i && !ovf;
        rd_adv = pop;
`endif
        if (!enable) begin
            wr_en  = 1'b0;
            rd_adv = 1'b0;
            ovf    = 1'b0;
        end

        wr_ptr_d    = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d    = rd_ptr_q + PTR_W'(rd_adv);
        count_d     = count_q + FILL_W'(wr_en) - FILL_W'(rd_adv);
        ovf_cnt_d   = ovf_cnt_q;
        if (ovf && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
        end
        new_msg_d   = wr_en;
        ovf_pulse_d = ovf;

        if (!enable) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            ovf_cnt_d = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_cnt_q   <= '0;
            new_msg_q   <= 1'b0;
            ovf_pulse_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_cnt_q   <= ovf_cnt_d;
            new_msg_q   <= new_msg_d;
            ovf_pulse_q <= ovf_pulse_d;
        end
    end

    assign wr_en_o       = wr_en;
    assign wr_ptr_o      = wr_ptr_q;
    assign rd_ptr_o      = rd_ptr_q;
    assign fill_level_o  = count_q;
    assign full_o        = full;
    assign empty_o       = empty;
    assign almost_full_o = (count_q >= FILL_W'(AFULL_LEVEL));
    assign new_msg_o     = new_msg_q;
    assign ovf_pulse_o   = ovf_pulse_q;
    assign ovf_count_o   = ovf_cnt_q;

endmodule

// File: rtl/can_message_fifo.sv
// CAN receive message FIFO: DEPTH-entry show-ahead buffer between the frame
// decoder and the message validator/host. Holds frame storage and output
// decode; pointer and status logic lives in can_fifo_ptr_ctrl.
// Optional CAN_MSG_FIFO_OVERWRITE_EN: overflowing push replaces the oldest frame.
module can_message_fifo
    import can_msg_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ID_WIDTH    = 11,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned AFULL_LEVEL = DEPTH - 1,
    parameter int unsigned OVF_CNT_W   = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            enable,
    can_message_fifo_if.slave bus
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             wr_en, empty;

    can_msg_t mem_q [DEPTH];
    can_msg_t msg_d;
    can_msg_t head;

    can_fifo_ptr_ctrl #(
        .DEPTH       (DEPTH),
        .AFULL_LEVEL (AFULL_LEVEL),
        .OVF_CNT_W   (OVF_CNT_W)
    ) u_ptr_ctrl (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .push_i        (bus.rx_message_valid),
        .pop_req_i     (bus.out_ready),
        .wr_en_o       (wr_en),
        .wr_ptr_o      (wr_ptr),
        .rd_ptr_o      (rd_ptr),
        .fill_level_o  (bus.fill_level),
        .full_o        (bus.buffer_full),
        .empty_o       (empty),
        .almost_full_o (bus.almost_full),
        .new_msg_o     (bus.new_message_available),
        .ovf_pulse_o   (bus.overflow_pulse),
        .ovf_count_o   (bus.overflow_count)
    );

    // Pack the incoming frame; payload bits past the byte count are kept as-is.
    always_comb begin
        msg_d            = '0;
        msg_d.identifier = CAN_ID_MAX_W'(bus.received_identifier);
        msg_d.dlc        = bus.received_dlc;
        msg_d.data       = CAN_DATA_MAX_W'(bus.received_data);
        msg_d.frame_type = can_frame_e'(bus.received_frame_type);
    end

    // Frame storage; contents need no reset since reads are masked when empty.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= msg_d;
        end
    end

    // Show-ahead head entry, forced to zero while the FIFO holds nothing.
    always_comb begin
        head = '0;
        if (!empty) begin
            head = mem_q[rd_ptr];
        end
    end

    assign bus.out_valid      = !empty;
    assign bus.buffer_empty   = empty;
    assign bus.out_identifier = head.identifier[ID_WIDTH-1:0];
    assign bus.out_dlc        = head.dlc;
    assign bus.out_data       = head.data[DATA_WIDTH-1:0];
    assign bus.out_frame_type = head.frame_type;
    assign bus.out_byte_count = dlc_to_bytes(head.dlc, head.frame_type);

    // Upper bits of the max-width fields are unused in narrower builds.
    logic unused_head_bits;
    assign unused_head_bits = ^{head.identifier, head.data};

endmodule

// File: tb/tb_can_message_fifo.sv
module tb_can_message_fifo;

    localparam int unsigned DEPTH      = 4;
    localparam int unsigned ID_WIDTH   = 11;
    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned OVF_CNT_W  = 8;
    localparam int unsigned AFULL      = DEPTH - 1;
    localparam int unsigned OVF_MAX    = (1 << OVF_CNT_W) - 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic enable  = 1'b1;

    always #5 clock = ~clock;

    can_message_fifo_if #(
        .DEPTH      (DEPTH),
        .ID_WIDTH   (ID_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .OVF_CNT_W  (OVF_CNT_W)
    ) bus ();

    can_message_fifo #(
        .DEPTH      (DEPTH),
        .ID_WIDTH   (ID_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .OVF_CNT_W  (OVF_CNT_W)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .bus     (bus)
    );

    typedef struct {
        logic [ID_WIDTH-1:0]   id;
        logic [3:0]            dlc;
        logic [DATA_WIDTH-1:0] data;
        logic                  ft;
    } frame_t;

    frame_t      q[$];
    int unsigned exp_cnt = 0;
    logic        exp_new = 1'b0;
    logic        exp_ovf = 1'b0;
    int          checks  = 0;
    int          errors  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_bytes(input logic [3:0] dlc, input logic ft);
        if (ft) return 4'd0;
        return (dlc > 4'd8) ? 4'd8 : dlc;
    endfunction

    task automatic set_frame(input logic [ID_WIDTH-1:0] id, input logic [3:0] dlc,
                             input logic [DATA_WIDTH-1:0] data, input logic ft);
        bus.received_identifier = id;
        bus.received_dlc        = dlc;
        bus.received_data       = data;
        bus.received_frame_type = ft;
    endtask

    function automatic logic [DATA_WIDTH-1:0] rnd_data();
        return {$urandom(), $urandom()};
    endfunction

    // Reference behaviour for the edge about to happen, from current inputs.
    task automatic model_step();
        frame_t f;
        bit     pop, full;
        f.id   = bus.received_identifier;
        f.dlc  = bus.received_dlc;
        f.data = bus.received_data;
        f.ft   = bus.received_frame_type;
        if (!reset_n || !enable) begin
            q.delete();
            exp_new = 1'b0;
            exp_ovf = 1'b0;
            exp_cnt = 0;
        end else begin
            pop     = (q.size() > 0) && bus.out_ready;
            full    = (q.size() == DEPTH);
            exp_new = 1'b0;
            exp_ovf = 1'b0;
            if (bus.rx_message_valid && full && !pop) begin
                exp_ovf = 1'b1;
                if (exp_cnt < OVF_MAX) exp_cnt++;
`ifdef CAN_MSG_FIFO_OVERWRITE_EN
                void'(q.pop_front());
                q.push_back(f);
                exp_new = 1'b1;
`endif
            end else begin
                if (pop) void'(q.pop_front());
                if (bus.rx_message_valid) begin
                    q.push_back(f);
                    exp_new = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("out_valid",    64'(bus.out_valid),             64'(n != 0));
        chk("fill_level",   64'(bus.fill_level),            64'(n));
        chk("buffer_full",  64'(bus.buffer_full),           64'(n == DEPTH));
        chk("buffer_empty", 64'(bus.buffer_empty),          64'(n == 0));
        chk("almost_full",  64'(bus.almost_full),           64'(n >= AFULL));
        chk("new_msg",      64'(bus.new_message_available), 64'(exp_new));
        chk("ovf_pulse",    64'(bus.overflow_pulse),        64'(exp_ovf));
        chk("ovf_count",    64'(bus.overflow_count),        64'(exp_cnt));
        if (n != 0) begin
            chk("out_id",    64'(bus.out_identifier), 64'(q[0].id));
            chk("out_dlc",   64'(bus.out_dlc),        64'(q[0].dlc));
            chk("out_data",  64'(bus.out_data),       64'(q[0].data));
            chk("out_ft",    64'(bus.out_frame_type), 64'(q[0].ft));
            chk("out_bytes", 64'(bus.out_byte_count), 64'(ref_bytes(q[0].dlc, q[0].ft)));
        end else begin
            chk("out_id_zero",    64'(bus.out_identifier), 64'(0));
            chk("out_data_zero",  64'(bus.out_data),       64'(0));
            chk("out_bytes_zero", 64'(bus.out_byte_count), 64'(0));
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check_all();
    endtask

    initial begin
        int unsigned sent;
        logic [ID_WIDTH-1:0] stall_id;
        bit stalled;

        bus.rx_message_valid = 1'b0;
        bus.out_ready        = 1'b0;
        set_frame('0, '0, '0, 1'b0);

        // Asynchronous reset
        repeat (2) @(posedge clock);
        #1;
        model_step();
        check_all();
        reset_n = 1'b1;

        // Two frames then a one-cycle enable drop
        for (int i = 0; i < 2; i++) begin
            set_frame(ID_WIDTH'(16 + i), 4'd8, rnd_data(), 1'b0);
            bus.rx_message_valid = 1'b1;
            tick();
        end
        bus.rx_message_valid = 1'b0;
        enable = 1'b0;
        tick();
        enable = 1'b1;
        chk("en_clear_fill",  64'(bus.fill_level),     64'(0));
        chk("en_clear_valid", 64'(bus.out_valid),      64'(0));
        chk("en_clear_ovf",   64'(bus.overflow_count), 64'(0));

        // Ordering: fill with 0x100..0x103 while stalled
        for (int i = 0; i < 4; i++) begin
            set_frame(ID_WIDTH'(11'h100 + i), 4'($urandom_range(0, 8)), rnd_data(), 1'b0);
            bus.rx_message_valid = 1'b1;
            tick();
        end
        bus.rx_message_valid = 1'b0;
        tick();
        chk("fill_full",  64'(bus.buffer_full),    64'(1));
        chk("fill_afull", 64'(bus.almost_full),    64'(1));
        chk("fill_head",  64'(bus.out_identifier), 64'(11'h100));

        // Overflow write on a full FIFO
        set_frame(11'h7FF, 4'd3, rnd_data(), 1'b0);
        bus.rx_message_valid = 1'b1;
        tick();
        bus.rx_message_valid = 1'b0;
        chk("ovf_pulse_hi", 64'(bus.overflow_pulse), 64'(1));
        chk("ovf_count_1",  64'(bus.overflow_count), 64'(1));
`ifdef CAN_MSG_FIFO_OVERWRITE_EN
        chk("ovf_head", 64'(bus.out_identifier), 64'(11'h101));
`else
        chk("ovf_head", 64'(bus.out_identifier), 64'(11'h100));
`endif
        tick();
        chk("ovf_pulse_lo", 64'(bus.overflow_pulse), 64'(0));

        // Push and pop together on a full FIFO
        set_frame(11'h200, 4'd2, rnd_data(), 1'b0);
        bus.rx_message_valid = 1'b1;
        bus.out_ready        = 1'b1;
        tick();
        bus.rx_message_valid = 1'b0;
        bus.out_ready        = 1'b0;
        chk("pp_fill", 64'(bus.fill_level),     64'(4));
        chk("pp_ovf",  64'(bus.overflow_count), 64'(1));

        // Drain in order
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8 && q.size() != 0; i++) tick();
        tick();
        bus.out_ready = 1'b0;
        chk("drain_empty", 64'(bus.buffer_empty), 64'(1));

        // Wrap/stall: 10 frames, out_ready toggling every 3 cycles
        sent = 0;
        for (int cyc = 0; cyc < 200 && (sent < 10 || q.size() != 0); cyc++) begin
            bus.out_ready        = ((cyc / 3) % 2) == 1;
            bus.rx_message_valid = (sent < 10) && (q.size() < DEPTH);
            set_frame(ID_WIDTH'($urandom()), 4'($urandom_range(0, 15)), rnd_data(), 1'($urandom()));
            stalled = (q.size() != 0) && !bus.out_ready;
            if (stalled) stall_id = q[0].id;
            if (bus.rx_message_valid) sent++;
            tick();
            if (stalled) chk("stall_stable", 64'(bus.out_identifier), 64'(stall_id));
        end
        bus.rx_message_valid = 1'b0;
        bus.out_ready        = 1'b0;
        chk("wrap_empty", 64'(bus.buffer_empty), 64'(1));

        // DLC decode
        set_frame(11'h321, 4'd12, rnd_data(), 1'b0);
        bus.rx_message_valid = 1'b1;
        tick();
        chk("bytes_dlc12", 64'(bus.out_byte_count), 64'(8));
        set_frame(11'h322, 4'd5, rnd_data(), 1'b1);
        tick();
        bus.rx_message_valid = 1'b0;
        bus.out_ready        = 1'b1;
        tick();
        chk("bytes_remote", 64'(bus.out_byte_count), 64'(0));
        tick();
        bus.out_ready = 1'b0;

        // Saturating overflow count
        bus.rx_message_valid = 1'b1;
        for (int i = 0; i < 4 + 300; i++) begin
            set_frame(ID_WIDTH'($urandom()), 4'($urandom_range(0, 15)), rnd_data(), 1'($urandom()));
            tick();
        end
        bus.rx_message_valid = 1'b0;
        tick();
        chk("ovf_saturate", 64'(bus.overflow_count), 64'(OVF_MAX));

        // Random traffic with occasional enable drops
        for (int i = 0; i < 300; i++) begin
            bus.rx_message_valid = 1'($urandom());
            bus.out_ready        = 1'($urandom());
            enable               = ($urandom_range(0, 39) != 0);
            set_frame(ID_WIDTH'($urandom()), 4'($urandom_range(0, 15)), rnd_data(), 1'($urandom()));
            tick();
        end
        enable               = 1'b1;
        bus.rx_message_valid = 1'b0;
        bus.out_ready        = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
